axi4_lite_arbiter: RTL and testbench
====================================

# axi4_lite_arbiter

Two-master, one-slave AXI4-Lite arbiter sharing the single memory port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write). Exactly one transaction is outstanding at a time. A granted transaction is held to completion. Ties are broken by fixed priority (LSU first) or by round-robin, selected at compile time. It sits between the core's IFU/LSU AXI masters and the SRAM/bus slave.

## Interface
- ADDR_W, 32, address width on all channels
- DATA_W, 32, data width; strobe width is DATA_W/8

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_araddr/m0_arvalid  in  ADDR_W/1  IFU read address
- m0_arready  out  1  IFU read address accepted
- m0_rdata/m0_rresp/m0_rvalid  out  DATA_W/2/1  IFU read data
- m0_rready  in  1  IFU read data accept
- m1_awaddr/m1_awvalid  in  ADDR_W/1  LSU write address
- m1_awready  out  1
- m1_wdata/m1_wstrb/m1_wvalid  in  DATA_W/DATA_W/8/1  LSU write data
- m1_wready  out  1
- m1_bresp/m1_bvalid  out  2/1  LSU write response
- m1_bready  in  1
- m1_araddr/m1_arvalid  in  ADDR_W/1  LSU read address
- m1_arready  out  1
- m1_rdata/m1_rresp/m1_rvalid  out  DATA_W/2/1
- m1_rready  in  1
- s_aw*/s_w*/s_ar*  out  per AXI4-Lite  slave request channels (addr, data, strb, valid)
- s_awready/s_wready/s_arready  in  1  slave request ready
- s_rdata/s_rresp/s_rvalid, s_bresp/s_bvalid  in  per AXI4-Lite  slave responses
- s_rready/s_bready  out  1

## Operation
- States: IDLE, M0_RD, M1_RD, M1_WR. The state register resets to IDLE.
- IDLE: no channel is forwarded. All master readies and valids are 0. All s_*valid, s_rready and s_bready are 0.
- Request detection in IDLE:
  - m0 requests on m0_arvalid.
  - m1 write requests on m1_awvalid|m1_wvalid.
  - m1 read requests on m1_arvalid.
  - Within m1, a write beats a read.
- Fixed priority (default): m1 beats m0.
- Transfer: the selected state is registered, so the grant is effective on the next cycle.
- Granted state routes the owner's AR/AW/W signals to the slave combinationally. Slave readies and responses go to the owner only. The non-owner sees every ready and valid at 0.
- M0_RD / M1_RD:
  - Forward AR until s_arvalid&&s_arready. A per-transaction ar_done flag blocks re-issue.
  - Then forward R. The transaction completes on s_rvalid&&owner_rready, and the next state is IDLE.
- M1_WR:
  - AW and W are forwarded independently, with aw_done and w_done flags. Each channel is gated off after its handshake.
  - The B channel is forwarded after both flags are set.
  - Complete on s_bvalid&&m1_bready, then go to IDLE.
- rresp/bresp pass through unmodified. The arbiter never generates errors.
- Reset asserted mid-transaction:
  - Immediately returns to IDLE and clears the done flags and the RR pointer.
  - All outputs go to 0.
  - A slave response in flight is the system's responsibility, because reset is global.

## Timing
- Reset values: every output is 0, including all *ready, *valid, s_* addr/data/strb, and master rdata/rresp/bresp.
- Grant latency: a request first visible in IDLE at cycle N gives s_*valid at N+1.
- Turnaround: completion handshake at cycle C → IDLE at C+1 → next grant at C+2. There is at least 1 idle cycle between transactions.
- Read with a zero-wait slave (arready=1 at grant, rvalid next cycle): master sees arready at N+1 and rvalid at N+2.
- Master valids must stay stable until ready, per AXI. The arbiter does not register master payloads.
- When a request arrives while a transaction is in progress, the requester stalls with ready=0 until IDLE re-arbitrates.

## Configuration
- AXI_ARB_RR_EN defined: round-robin tie-break between m0 and m1.
  - A 1-bit last_grant register is updated on each grant. It resets to "m0", so the first tie goes to m1.
  - On a tie, the master not last granted wins.
  - A lone requester always wins, regardless of last_grant.
- AXI_ARB_RR_EN undefined: fixed priority, m1 over m0, and no last_grant register.

## Test plan
- Lone IFU read, addr 0x8000_0000, slave returns 0x0000_0413 after 1 cycle → m0 gets rvalid with that data. The FSM is back in IDLE one cycle after the handshake. All m1 readies stay 0.
- LSU write, AW at cycle 0 and W at cycle 3, addr 0x8000_1000, data 0xDEAD_BEEF, strb 0xF:
  - s_awvalid drops after its handshake.
  - B is not forwarded before the W handshake.
  - m1 receives bresp=0.
- Simultaneous m0 read and m1 read, held for 4 transactions:
  - Fixed build grants m1 all 4 times.
  - With AXI_ARB_RR_EN, grants go m1, m0, m1, m0.
- m1 asserts arvalid and awvalid together → the write is serviced first, then the read.
- Slave holds arready=0 for 5 cycles during an m0 read → s_arvalid stays high and address-stable. m1's request is not granted until m0's R completes.
- rst asserted during M1_WR after the AW handshake only → all outputs 0 the same cycle. After release, the FSM is IDLE and a fresh write completes normally. rresp=2 from the slave passes to the master unchanged.

Source files
------------

// File: rtl/axi4_lite_arbiter_if.sv
// One AXI4-Lite link. The master modport drives the request channels and the
// slave modport drives the ready and response signals.
interface axi4_lite_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter, one transaction at a time.
// Define AXI_ARB_RR_EN for round-robin tie-break; the default build gives the LSU fixed priority.
//
// state | meaning
// IDLE  | nothing forwarded, arbitrate pending requests
// M0_RD | IFU read owns the slave: AR, then R
// M1_RD | LSU read owns the slave: AR, then R
// M1_WR | LSU write owns the slave: AW and W independently, then B
module axi4_lite_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   axi4_lite_arbiter_if.slave  m0,
   axi4_lite_arbiter_if.slave  m1,
   axi4_lite_arbiter_if.master s
);
   typedef enum logic [1:0] {IDLE = 2'd0, M0_RD = 2'd1, M1_RD = 2'd2, M1_WR = 2'd3} state_t;

   state_t state_q, state_d;
   logic   ar_done_q, ar_done_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q, w_done_d;
   logic   own_m0_rd, own_m1_rd, own_wr, wr_resp_en;
   logic   m0_req, m1_wr_req, m1_req, pick_m1;

   assign own_m0_rd  = (state_q == M0_RD);
   assign own_m1_rd  = (state_q == M1_RD);
   assign own_wr     = (state_q == M1_WR);
   assign wr_resp_en = own_wr & aw_done_q & w_done_q;

   assign m0_req    = m0.arvalid;
   assign m1_wr_req = m1.awvalid | m1.wvalid;
   assign m1_req    = m1_wr_req | m1.arvalid;

`ifdef AXI_ARB_RR_EN
   logic last_grant_q;  // 1: the LSU received the most recent grant

   assign pick_m1 = m1_req & (~m0_req | ~last_grant_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant_q <= 1'b0;
      else if (state_q == IDLE && (m0_req || m1_req))
         last_grant_q <= pick_m1;
   end
`else
   assign pick_m1 = m1_req;
`endif

   assign s.araddr  = own_m0_rd ? m0.araddr : (own_m1_rd ? m1.araddr : {ADDR_W{1'b0}});
   assign s.arvalid = ~ar_done_q & ((own_m0_rd & m0.arvalid) | (own_m1_rd & m1.arvalid));
   assign s.rready  = ar_done_q & ((own_m0_rd & m0.rready) | (own_m1_rd & m1.rready));
   assign s.awaddr  = own_wr ? m1.awaddr : {ADDR_W{1'b0}};
   assign s.awvalid = own_wr & ~aw_done_q & m1.awvalid;
   assign s.wdata   = own_wr ? m1.wdata : {DATA_W{1'b0}};
   assign s.wstrb   = own_wr ? m1.wstrb : {(DATA_W/8){1'b0}};
   assign s.wvalid  = own_wr & ~w_done_q & m1.wvalid;
   assign s.bready  = wr_resp_en & m1.bready;

   assign m0.arready = own_m0_rd & ~ar_done_q & s.arready;
   assign m0.rvalid  = own_m0_rd & ar_done_q & s.rvalid;
   assign m0.rdata   = own_m0_rd ? s.rdata : {DATA_W{1'b0}};
   assign m0.rresp   = own_m0_rd ? s.rresp : 2'b00;
   assign m0.awready = 1'b0;
   assign m0.wready  = 1'b0;
   assign m0.bvalid  = 1'b0;
   assign m0.bresp   = 2'b00;

   assign m1.arready = own_m1_rd & ~ar_done_q & s.arready;
   assign m1.rvalid  = own_m1_rd & ar_done_q & s.rvalid;
   assign m1.rdata   = own_m1_rd ? s.rdata : {DATA_W{1'b0}};
   assign m1.rresp   = own_m1_rd ? s.rresp : 2'b00;
   assign m1.awready = own_wr & ~aw_done_q & s.awready;
   assign m1.wready  = own_wr & ~w_done_q & s.wready;
   assign m1.bvalid  = wr_resp_en & s.bvalid;
   assign m1.bresp   = wr_resp_en ? s.bresp : 2'b00;

   // The IFU never writes; its write-request inputs are intentionally ignored.
   logic unused_m0_wr;
   assign unused_m0_wr = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

   always_comb begin
      state_d   = state_q;
      ar_done_d = ar_done_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (pick_m1)
               state_d = m1_wr_req ? M1_WR : M1_RD;
            else if (m0_req)
               state_d = M0_RD;
         end
         M0_RD, M1_RD: begin
            if (s.arvalid && s.arready)
               ar_done_d = 1'b1;
            if (s.rvalid && s.rready) begin
               state_d   = IDLE;
               ar_done_d = 1'b0;
            end
         end
         M1_WR: begin
            if (s.awvalid && s.awready)
               aw_done_d = 1'b1;
            if (s.wvalid && s.wready)
               w_done_d = 1'b1;
            if (s.bvalid && s.bready) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: masters and slave driven step by step,
// outputs compared against hand-derived values.
module tb_axi4_lite_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic exp_m1;

   axi4_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
   axi4_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
   axi4_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

   axi4_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .m0  (m0_bus),
      .m1  (m1_bus),
      .s   (s_bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      m0_bus.awaddr = '0; m0_bus.awvalid = 0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
      m0_bus.wvalid = 0; m0_bus.bready = 0; m0_bus.araddr = '0; m0_bus.arvalid = 0; m0_bus.rready = 0;
      m1_bus.awaddr = '0; m1_bus.awvalid = 0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
      m1_bus.wvalid = 0; m1_bus.bready = 0; m1_bus.araddr = '0; m1_bus.arvalid = 0; m1_bus.rready = 0;
      s_bus.awready = 0; s_bus.wready = 0; s_bus.bresp = 0; s_bus.bvalid = 0;
      s_bus.arready = 0; s_bus.rdata = '0; s_bus.rresp = 0; s_bus.rvalid = 0;

      // Reset values
      #1 rst = 1'b1;
      settle();
      chk("rst_s_arvalid", s_bus.arvalid, 0);
      chk("rst_s_awvalid", s_bus.awvalid, 0);
      chk("rst_s_wvalid", s_bus.wvalid, 0);
      chk("rst_s_awaddr", s_bus.awaddr, 0);
      chk("rst_s_araddr", s_bus.araddr, 0);
      chk("rst_s_wdata", s_bus.wdata, 0);
      chk("rst_s_wstrb", s_bus.wstrb, 0);
      chk("rst_s_rready", s_bus.rready, 0);
      chk("rst_s_bready", s_bus.bready, 0);
      chk("rst_m0_arready", m0_bus.arready, 0);
      chk("rst_m0_rdata", m0_bus.rdata, 0);
      chk("rst_m0_awready", m0_bus.awready, 0);
      chk("rst_m1_bvalid", m1_bus.bvalid, 0);
      chk("rst_m1_bresp", m1_bus.bresp, 0);
      tick();
      tick();
      rst = 1'b0;

      // Tied reads from both masters, four transactions
      m0_bus.araddr = 32'h100; m0_bus.arvalid = 1; m0_bus.rready = 1;
      m1_bus.araddr = 32'h200; m1_bus.arvalid = 1; m1_bus.rready = 1;
      s_bus.arready = 1;
      settle();
      chk("idle_s_arvalid", s_bus.arvalid, 0);
      for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_RR_EN
         exp_m1 = (k % 2 == 0);
`else
         exp_m1 = 1'b1;
`endif
         tick();
         settle();
         chk("tie_m1_arready", m1_bus.arready, exp_m1);
         chk("tie_m0_arready", m0_bus.arready, !exp_m1);
         chk("tie_s_araddr", s_bus.araddr, exp_m1 ? 32'h200 : 32'h100);
         tick();
         s_bus.rvalid = 1; s_bus.rdata = 32'h1000 + k;
         settle();
         chk("tie_m1_rvalid", m1_bus.rvalid, exp_m1);
         chk("tie_m0_rvalid", m0_bus.rvalid, !exp_m1);
         chk("tie_rdata", exp_m1 ? m1_bus.rdata : m0_bus.rdata, 32'h1000 + k);
         tick();
         s_bus.rvalid = 0;
         settle();
         chk("tie_idle_s_arvalid", s_bus.arvalid, 0);
      end

      // Lone IFU read, zero-wait slave
      m1_bus.arvalid = 0;
      m0_bus.araddr = 32'h8000_0000;
      tick();
      settle();
      chk("ifu_s_arvalid", s_bus.arvalid, 1);
      chk("ifu_s_araddr", s_bus.araddr, 32'h8000_0000);
      chk("ifu_m0_arready", m0_bus.arready, 1);
      chk("ifu_m1_arready", m1_bus.arready, 0);
      chk("ifu_m1_awready", m1_bus.awready, 0);
      chk("ifu_m1_wready", m1_bus.wready, 0);
      tick();
      m0_bus.arvalid = 0; s_bus.rvalid = 1; s_bus.rdata = 32'h0000_0413; s_bus.rresp = 0;
      settle();
      chk("ifu_m0_rvalid", m0_bus.rvalid, 1);
      chk("ifu_m0_rdata", m0_bus.rdata, 32'h0000_0413);
      chk("ifu_m0_rresp", m0_bus.rresp, 0);
      chk("ifu_m1_rvalid", m1_bus.rvalid, 0);
      chk("ifu_s_arvalid_done", s_bus.arvalid, 0);
      tick();
      s_bus.rvalid = 0;
      settle();
      chk("ifu_idle_m0_rvalid", m0_bus.rvalid, 0);
      chk("ifu_idle_m0_rdata", m0_bus.rdata, 0);
      chk("ifu_idle_s_rready", s_bus.rready, 0);

      // LSU write: AW first, W three cycles later
      m1_bus.awaddr = 32'h8000_1000; m1_bus.awvalid = 1; m1_bus.bready = 1;
      s_bus.awready = 1; s_bus.wready = 1;
      settle();
      chk("wr_idle_s_awvalid", s_bus.awvalid, 0);
      tick();
      settle();
      chk("wr_s_awvalid", s_bus.awvalid, 1);
      chk("wr_s_awaddr", s_bus.awaddr, 32'h8000_1000);
      chk("wr_m1_awready", m1_bus.awready, 1);
      chk("wr_s_wvalid_early", s_bus.wvalid, 0);
      chk("wr_m0_arready", m0_bus.arready, 0);
      tick();
      s_bus.bvalid = 1;
      settle();
      chk("wr_s_awvalid_drop", s_bus.awvalid, 0);
      chk("wr_m1_awready_drop", m1_bus.awready, 0);
      chk("wr_m1_bvalid_early", m1_bus.bvalid, 0);
      chk("wr_s_bready_early", s_bus.bready, 0);
      tick();
      m1_bus.awvalid = 0; m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wstrb = 4'hF; m1_bus.wvalid = 1;
      settle();
      chk("wr_s_wvalid", s_bus.wvalid, 1);
      chk("wr_s_wdata", s_bus.wdata, 32'hDEAD_BEEF);
      chk("wr_s_wstrb", s_bus.wstrb, 4'hF);
      chk("wr_m1_wready", m1_bus.wready, 1);
      chk("wr_m1_bvalid_w", m1_bus.bvalid, 0);
      tick();
      m1_bus.wvalid = 0; s_bus.bresp = 0;
      settle();
      chk("wr_m1_bvalid", m1_bus.bvalid, 1);
      chk("wr_m1_bresp", m1_bus.bresp, 0);
      chk("wr_s_bready", s_bus.bready, 1);
      chk("wr_s_wvalid_drop", s_bus.wvalid, 0);
      tick();
      s_bus.bvalid = 0;
      settle();
      chk("wr_idle_m1_bvalid", m1_bus.bvalid, 0);
      chk("wr_idle_s_awaddr", s_bus.awaddr, 0);
      chk("wr_idle_s_wdata", s_bus.wdata, 0);

      // LSU write and read requested together: write first
      m1_bus.awaddr = 32'h2000; m1_bus.awvalid = 1; m1_bus.wdata = 32'h1122_3344;
      m1_bus.wstrb = 4'h3; m1_bus.wvalid = 1; m1_bus.araddr = 32'h3000; m1_bus.arvalid = 1;
      tick();
      settle();
      chk("wvr_s_awvalid", s_bus.awvalid, 1);
      chk("wvr_s_wvalid", s_bus.wvalid, 1);
      chk("wvr_s_arvalid", s_bus.arvalid, 0);
      chk("wvr_m1_arready", m1_bus.arready, 0);
      tick();
      m1_bus.awvalid = 0; m1_bus.wvalid = 0; s_bus.bvalid = 1; s_bus.bresp = 0;
      settle();
      chk("wvr_m1_bvalid", m1_bus.bvalid, 1);
      tick();
      s_bus.bvalid = 0;
      settle();
      chk("wvr_idle_s_arvalid", s_bus.arvalid, 0);
      tick();
      settle();
      chk("wvr_rd_s_arvalid", s_bus.arvalid, 1);
      chk("wvr_rd_s_araddr", s_bus.araddr, 32'h3000);
      chk("wvr_rd_m1_arready", m1_bus.arready, 1);
      tick();
      m1_bus.arvalid = 0; s_bus.rvalid = 1; s_bus.rdata = 32'hCAFE_0001;
      settle();
      chk("wvr_m1_rvalid", m1_bus.rvalid, 1);
      chk("wvr_m1_rdata", m1_bus.rdata, 32'hCAFE_0001);
      tick();
      s_bus.rvalid = 0;

      // IFU read with slave stalling AR for five cycles, LSU waiting
      m0_bus.araddr = 32'h8000_0040; m0_bus.arvalid = 1; s_bus.arready = 0;
      tick();
      m1_bus.araddr = 32'h300; m1_bus.arvalid = 1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_s_arvalid", s_bus.arvalid, 1);
         chk("stall_s_araddr", s_bus.araddr, 32'h8000_0040);
         chk("stall_m0_arready", m0_bus.arready, 0);
         chk("stall_m1_arready", m1_bus.arready, 0);
         tick();
      end
      s_bus.arready = 1;
      settle();
      chk("stall_m0_arready_hs", m0_bus.arready, 1);
      tick();
      m0_bus.arvalid = 0;
      settle();
      chk("stall_s_arvalid_done", s_bus.arvalid, 0);
      chk("stall_m1_arready_r", m1_bus.arready, 0);
      chk("stall_m0_rvalid_wait", m0_bus.rvalid, 0);
      tick();
      s_bus.rvalid = 1; s_bus.rdata = 32'h55;
      settle();
      chk("stall_m0_rvalid", m0_bus.rvalid, 1);
      chk("stall_m1_arready_c", m1_bus.arready, 0);
      tick();
      s_bus.rvalid = 0;
      settle();
      chk("stall_idle_m1_arready", m1_bus.arready, 0);
      tick();
      settle();
      chk("stall_m1_arready_grant", m1_bus.arready, 1);
      chk("stall_m1_s_araddr", s_bus.araddr, 32'h300);
      tick();
      m1_bus.arvalid = 0; s_bus.rvalid = 1; s_bus.rdata = 32'h66;
      settle();
      chk("stall_m1_rvalid", m1_bus.rvalid, 1);
      tick();
      s_bus.rvalid = 0;

      // Reset during LSU write after the AW handshake only
      m1_bus.awaddr = 32'h4000; m1_bus.awvalid = 1; m1_bus.wvalid = 0;
      tick();
      settle();
      chk("rstwr_s_awvalid", s_bus.awvalid, 1);
      tick();
      m1_bus.awvalid = 0; rst = 1'b1;
      m1_bus.wdata = 32'hA5A5_A5A5; m1_bus.wvalid = 1; s_bus.bvalid = 1;
      settle();
      chk("rstwr_s_wvalid", s_bus.wvalid, 0);
      chk("rstwr_m1_wready", m1_bus.wready, 0);
      chk("rstwr_s_awaddr", s_bus.awaddr, 0);
      chk("rstwr_s_wdata", s_bus.wdata, 0);
      chk("rstwr_m1_bvalid", m1_bus.bvalid, 0);
      chk("rstwr_s_bready", s_bus.bready, 0);
      tick();
      rst = 1'b0; s_bus.bvalid = 0; m1_bus.awvalid = 1;
      settle();
      chk("rstwr_idle_s_awvalid", s_bus.awvalid, 0);
      tick();
      settle();
      chk("rstwr_new_s_awvalid", s_bus.awvalid, 1);
      chk("rstwr_new_s_wvalid", s_bus.wvalid, 1);
      chk("rstwr_new_s_wdata", s_bus.wdata, 32'hA5A5_A5A5);
      tick();
      m1_bus.awvalid = 0; m1_bus.wvalid = 0; s_bus.bvalid = 1; s_bus.bresp = 2'd2;
      settle();
      chk("rstwr_m1_bvalid_new", m1_bus.bvalid, 1);
      chk("rstwr_m1_bresp", m1_bus.bresp, 2'd2);
      tick();
      s_bus.bvalid = 0; s_bus.bresp = 0;
      m0_bus.araddr = 32'h8000_0080; m0_bus.arvalid = 1;
      tick();
      settle();
      chk("rresp_m0_arready", m0_bus.arready, 1);
      tick();
      m0_bus.arvalid = 0; s_bus.rvalid = 1; s_bus.rresp = 2'd2; s_bus.rdata = 32'h77;
      settle();
      chk("rresp_m0_rvalid", m0_bus.rvalid, 1);
      chk("rresp_m0_rresp", m0_bus.rresp, 2'd2);
      tick();
      s_bus.rvalid = 0; s_bus.rresp = 0;
      settle();
      chk("rresp_idle_m0_rvalid", m0_bus.rvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
